ysyx_23060025_csr_exu: RTL
==========================

// Module: ysyx_23060025_csr_exu
// PURPOSE
//  Execute unit for SYSTEM-class instructions: CSRRW/CSRRS/CSRRC (reg and imm forms), ECALL, MRET.
//  - Sits between the decoder/dispatch stage and the CSR register file.
//  - Reads the old CSR value, computes the new value, then drives the CSR file's single write/trap port for one cycle.
//  - Returns the rd write-back value and a PC redirect (trap vector or mepc) to the writeback/PC stage.
// PARAMETERS
//  DATA_WIDTH   32  datapath width
//  ECALL_CAUSE  11  mcause value written on ECALL (environment call from M-mode)
// PORTS
//  clock          in   1   core clock
//  reset          in   1   synchronous, active-high
//  in_valid       in   1   dispatch presents an op
//  in_ready       out  1   block can accept (high only in IDLE)
//  csr_op_i       in   3   `CSR_RW/`CSR_RS/`CSR_RC/`CSR_ECALL/`CSR_MRET/`CSR_NONE
//  csr_addr_i     in   12  CSR address field of the instruction
//  rs1_data_i     in   32  rs1 value (register forms)
//  zimm_i         in   5   rs1 field as zero-extended immediate
//  use_imm_i      in   1   1 = immediate form (CSRRWI/SI/CI)
//  rs1_zero_i     in   1   rs1 field == x0 (register forms)
//  pc_i           in   32  PC of the instruction
//  csr_raddr_o    out  12  read address to CSR file
//  csr_rdata_i    in   32  combinational read data from CSR file
//  csr_waddr_o    out  12  write address to CSR file
//  csr_wdata_o    out  32  write data to CSR file
//  csr_type_o     out  3   op to CSR file; non-zero for exactly one cycle per write/trap
//  csr_mepc_o     out  32  mepc value for ECALL
//  csr_mcause_o   out  32  mcause value for ECALL
//  csr_mtvec_i    in   32  current mtvec
//  csr_mepc_i     in   32  current mepc
//  out_valid      out  1   result available
//  out_ready      in   1   consumer accepts result
//  rd_wdata_o     out  32  value for rd
//  redirect_o     out  1   PC must be redirected
//  redirect_pc_o  out  32  redirect target
// BEHAVIOUR
//  Op encodings: NONE 3'b000, RW 3'b001, RS 3'b010, RC 3'b100, ECALL 3'b011, MRET 3'b101.
//  - Odd parity = CSR write op; 3'b111 is never driven and is treated as NONE on input.
//  Reset: state=IDLE; all outputs 0 except in_ready=1.
//  - Reset in any state aborts the op immediately; no CSR write is issued after reset asserts.
//  FSM IDLE->READ->WRITE->RESP->IDLE.
//  - IDLE: in_ready=1. On in_valid: latch all inputs, go to READ.
//  - READ: csr_raddr_o=latched addr. Sample csr_rdata_i, csr_mtvec_i, csr_mepc_i at the clock edge. Go to WRITE.
//  - WRITE: csr_type_o/waddr/wdata/mepc/mcause valid for exactly this cycle, then RESP.
//  - RESP: out_valid=1, results stable. Stay until out_ready; then IDLE.
//  Latency: accept edge T; out_valid high from T+3. One op in flight; no back-to-back overlap.
//  src = use_imm_i ? zext(zimm_i) : rs1_data_i; old = sampled CSR value.
//  - RW: wdata=src; write always.
//  - RS: wdata=old|src. RC: wdata=old&~src.
//  - RS/RC write is suppressed (csr_type_o=0 in WRITE) when imm form with zimm==0, or reg form with rs1_zero_i=1.
//  - rd_wdata_o=old for RW/RS/RC; redirect_o=0.
//  ECALL: csr_type_o=`CSR_ECALL, csr_mepc_o=pc, csr_mcause_o=ECALL_CAUSE.
//  - redirect_o=1, redirect_pc_o={mtvec[31:2],2'b00}, rd_wdata_o=0.
//  MRET: csr_type_o=`CSR_NONE; redirect_o=1, redirect_pc_o=sampled mepc, rd_wdata_o=0.
//  NONE/illegal: no write, no redirect, rd_wdata_o=0; still traverses all states (fixed latency).
//  Unmapped addresses are passed through unchanged; CSR-file decoding is not this block's concern.
//  csr_type_o=0 and csr_waddr_o/csr_wdata_o=0 outside WRITE.
// STRUCTURE
//  Shared define file: op encodings, CSR address/index macros, ECALL_CAUSE default, FSM state encodings (2-bit).
//  Sub-module ysyx_23060025_csr_alu: combinational (op, old, src) -> (wdata, wen).
//  FSM, input latches and result registers stay in this module.
// TESTING
//  1 CSRRW mtvec(0x305), rs1=0x80000100, old=0 -> one WRITE cycle type=RW wdata=0x80000100; rd=0; out_valid at T+3.
//  2 CSRRS mstatus, rs1_zero_i=1, old=0x1800 -> csr_type_o never non-zero; rd=0x1800.
//  3 CSRRCI mstatus, zimm=0x08, old=0x1808 -> wdata=0x1800, rd=0x1808.
//  4 ECALL pc=0x80000040, mtvec=0x80001003 -> type=ECALL, mepc=0x80000040, mcause=11, redirect_pc=0x80001000.
//  5 MRET, mepc=0x80000044 -> no write, redirect=1, redirect_pc=0x80000044; out_ready low 5 cycles holds outputs stable.
//  6 Reset asserted in READ of a CSRRW -> no write pulse, in_ready=1 and out_valid=0 next cycle.

Source files
------------

// File: rtl/ysyx_23060025_csr_exu_pkg.sv
// Shared definitions for the SYSTEM-instruction execute unit.
// Holds the CSR op encodings (odd parity marks a CSR write op), common CSR
// addresses, the default ECALL mcause and the 2-bit FSM state encoding.
package ysyx_23060025_csr_exu_pkg;

    typedef logic [2:0] csr_op_t;

    localparam csr_op_t CSR_NONE  = 3'b000;
    localparam csr_op_t CSR_RW    = 3'b001;
    localparam csr_op_t CSR_RS    = 3'b010;
    localparam csr_op_t CSR_ECALL = 3'b011;
    localparam csr_op_t CSR_RC    = 3'b100;
    localparam csr_op_t CSR_MRET  = 3'b101;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // Environment call from M-mode.
    localparam int ECALL_CAUSE_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // 3'b111 is never issued by dispatch; fold it onto NONE so it can never
    // masquerade as a write op (it has odd parity).
    function automatic csr_op_t sanitize_op(input csr_op_t op);
        return (op == 3'b111) ? CSR_NONE : op;
    endfunction

    // RW/RS/RC: the ops that return the old CSR value to rd.
    function automatic logic is_csr_rw_op(input csr_op_t op);
        return (^op) && (op != 3'b111);
    endfunction

endpackage

// File: rtl/ysyx_23060025_csr_exu_if.sv
// Bundle of every non-clock signal of the CSR execute unit.
//   dispatch side : in_valid/in_ready, csr_op_i, csr_addr_i, rs1_data_i,
//                   zimm_i, use_imm_i, rs1_zero_i, pc_i
//   CSR file side : csr_raddr_o/csr_rdata_i, csr_waddr_o, csr_wdata_o,
//                   csr_type_o, csr_mepc_o, csr_mcause_o, csr_mtvec_i, csr_mepc_i
//   result side   : out_valid/out_ready, rd_wdata_o, redirect_o, redirect_pc_o
// modport slave  : the execute unit itself
// modport master : the surrounding pipeline / CSR file
interface ysyx_23060025_csr_exu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            csr_op_i;
    logic [11:0]           csr_addr_i;
    logic [DATA_WIDTH-1:0] rs1_data_i;
    logic [4:0]            zimm_i;
    logic                  use_imm_i;
    logic                  rs1_zero_i;
    logic [DATA_WIDTH-1:0] pc_i;

    logic [11:0]           csr_raddr_o;
    logic [DATA_WIDTH-1:0] csr_rdata_i;
    logic [11:0]           csr_waddr_o;
    logic [DATA_WIDTH-1:0] csr_wdata_o;
    logic [2:0]            csr_type_o;
    logic [DATA_WIDTH-1:0] csr_mepc_o;
    logic [DATA_WIDTH-1:0] csr_mcause_o;
    logic [DATA_WIDTH-1:0] csr_mtvec_i;
    logic [DATA_WIDTH-1:0] csr_mepc_i;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] rd_wdata_o;
    logic                  redirect_o;
    logic [DATA_WIDTH-1:0] redirect_pc_o;

    modport slave (
        input  in_valid, csr_op_i, csr_addr_i, rs1_data_i, zimm_i, use_imm_i,
               rs1_zero_i, pc_i, csr_rdata_i, csr_mtvec_i, csr_mepc_i, out_ready,
        output in_ready, csr_raddr_o, csr_waddr_o, csr_wdata_o, csr_type_o,
               csr_mepc_o, csr_mcause_o, out_valid, rd_wdata_o, redirect_o,
               redirect_pc_o
    );

    modport master (
        output in_valid, csr_op_i, csr_addr_i, rs1_data_i, zimm_i, use_imm_i,
               rs1_zero_i, pc_i, csr_rdata_i, csr_mtvec_i, csr_mepc_i, out_ready,
        input  in_ready, csr_raddr_o, csr_waddr_o, csr_wdata_o, csr_type_o,
               csr_mepc_o, csr_mcause_o, out_valid, rd_wdata_o, redirect_o,
               redirect_pc_o
    );

endinterface

// File: rtl/ysyx_23060025_csr_alu.sv
// Combinational CSR read-modify-write datapath.
//   op_i       : sanitized CSR op
//   old_i      : current CSR value
//   src_i      : rs1 value or zero-extended immediate
//   src_zero_i : rs1 is x0 (register form) or zimm==0 (immediate form)
//   wdata_o    : new CSR value
//   wen_o      : a CSR write must be issued
module ysyx_23060025_csr_alu
    import ysyx_23060025_csr_exu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  csr_op_t               op_i,
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [DATA_WIDTH-1:0] src_i,
    input  logic                  src_zero_i,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  wen_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        wdata_o = '0;
        wen_o   = 1'b0;
        unique case (op_i)
            CSR_RW: begin
                wdata_o = src_i;
                wen_o   = 1'b1;
            end
            // Set/clear with a zero source is a pure read: no side effects.
            CSR_RS: begin
                wdata_o = old_i | src_i;
                wen_o   = !src_zero_i;
            end
            CSR_RC: begin
                wdata_o = old_i & ~src_i;
                wen_o   = !src_zero_i;
            end
            default: begin
                wdata_o = '0;
                wen_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060025_csr_exu.sv
// Execute unit for SYSTEM instructions (CSRRW/S/C and immediate forms, ECALL,
// MRET). Walks IDLE -> READ -> WRITE -> RESP for every op so latency is fixed.
//   clock, reset : core clock, synchronous active-high reset
//   bus (slave)  : dispatch handshake, CSR file read/write/trap port and
//                  result handshake; see ysyx_23060025_csr_exu_if
// All outputs are registered; the CSR write/trap port is non-zero only
// during the single WRITE cycle.
module ysyx_23060025_csr_exu
    import ysyx_23060025_csr_exu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ECALL_CAUSE = ECALL_CAUSE_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    ysyx_23060025_csr_exu_if.slave  bus
);

    state_e                state_q;

    // Latched instruction fields
    csr_op_t               op_q;
    logic [11:0]           addr_q;
    logic [DATA_WIDTH-1:0] src_q;
    logic                  src_zero_q;
    logic [DATA_WIDTH-1:0] pc_q;

    // CSR file values sampled at the end of READ
    logic [DATA_WIDTH-1:0] old_q;
    logic [DATA_WIDTH-1:0] mtvec_q;
    logic [DATA_WIDTH-1:0] mepc_q;

    // Output registers
    logic                  in_ready_q;
    logic [11:0]           csr_raddr_q;
    logic [11:0]           csr_waddr_q;
    logic [DATA_WIDTH-1:0] csr_wdata_q;
    csr_op_t               csr_type_q;
    logic [DATA_WIDTH-1:0] csr_mepc_q;
    logic [DATA_WIDTH-1:0] csr_mcause_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] rd_wdata_q;
    logic                  redirect_q;
    logic [DATA_WIDTH-1:0] redirect_pc_q;

    logic [DATA_WIDTH-1:0] alu_wdata;
    logic                  alu_wen;

    // The ALU sees the live read data during READ so the write registers can
    // be loaded on the same edge that ends READ.
    ysyx_23060025_csr_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .op_i       (op_q),
        .old_i      (bus.csr_rdata_i),
        .src_i      (src_q),
        .src_zero_i (src_zero_q),
        .wdata_o    (alu_wdata),
        .wen_o      (alu_wen)
    );

    // NOTE: all state here is sequential and uses non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            // Reset clears everything, so an op caught mid-flight is dropped
            // before it can reach the WRITE cycle.
            state_q       <= ST_IDLE;
            op_q          <= CSR_NONE;
            addr_q        <= '0;
            src_q         <= '0;
            src_zero_q    <= 1'b0;
            pc_q          <= '0;
            old_q         <= '0;
            mtvec_q       <= '0;
            mepc_q        <= '0;
            in_ready_q    <= 1'b1;
            csr_raddr_q   <= '0;
            csr_waddr_q   <= '0;
            csr_wdata_q   <= '0;
            csr_type_q    <= CSR_NONE;
            csr_mepc_q    <= '0;
            csr_mcause_q  <= '0;
            out_valid_q   <= 1'b0;
            rd_wdata_q    <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_q        <= sanitize_op(bus.csr_op_i);
                        addr_q      <= bus.csr_addr_i;
                        src_q       <= bus.use_imm_i
                                       ? {{(DATA_WIDTH-5){1'b0}}, bus.zimm_i}
                                       : bus.rs1_data_i;
                        src_zero_q  <= bus.use_imm_i ? (bus.zimm_i == 5'd0)
                                                     : bus.rs1_zero_i;
                        pc_q        <= bus.pc_i;
                        in_ready_q  <= 1'b0;
                        csr_raddr_q <= bus.csr_addr_i;
                        state_q     <= ST_READ;
                    end
                end

                ST_READ: begin
                    old_q       <= bus.csr_rdata_i;
                    mtvec_q     <= bus.csr_mtvec_i;
                    mepc_q      <= bus.csr_mepc_i;
                    csr_raddr_q <= '0;
                    if (op_q == CSR_ECALL) begin
                        csr_type_q   <= CSR_ECALL;
                        csr_waddr_q  <= addr_q;
                        csr_wdata_q  <= '0;
                        csr_mepc_q   <= pc_q;
                        csr_mcause_q <= DATA_WIDTH'(ECALL_CAUSE);
                    end else if (alu_wen) begin
                        csr_type_q  <= op_q;
                        csr_waddr_q <= addr_q;
                        csr_wdata_q <= alu_wdata;
                    end
                    state_q <= ST_WRITE;
                end

                ST_WRITE: begin
                    // Write/trap port drops back to zero after one cycle.
                    csr_type_q    <= CSR_NONE;
                    csr_waddr_q   <= '0;
                    csr_wdata_q   <= '0;
                    csr_mepc_q    <= '0;
                    csr_mcause_q  <= '0;
                    rd_wdata_q    <= is_csr_rw_op(op_q) ? old_q : '0;
                    redirect_q    <= (op_q == CSR_ECALL) || (op_q == CSR_MRET);
                    redirect_pc_q <= (op_q == CSR_ECALL) ? {mtvec_q[DATA_WIDTH-1:2], 2'b00}
                                   : (op_q == CSR_MRET)  ? mepc_q
                                   : '0;
                    out_valid_q   <= 1'b1;
                    state_q       <= ST_RESP;
                end

                ST_RESP: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.csr_raddr_o   = csr_raddr_q;
    assign bus.csr_waddr_o   = csr_waddr_q;
    assign bus.csr_wdata_o   = csr_wdata_q;
    assign bus.csr_type_o    = csr_type_q;
    assign bus.csr_mepc_o    = csr_mepc_q;
    assign bus.csr_mcause_o  = csr_mcause_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.rd_wdata_o    = rd_wdata_q;
    assign bus.redirect_o    = redirect_q;
    assign bus.redirect_pc_o = redirect_pc_q;

endmodule
